ctrl_pipe: RTL and testbench

Parametrised control-signal pipeline carrying a decoded control word, destination register and source registers from decode through the E, M and W stages. Per-stage valid bits, external stall/flush per stage, automatic bubble insertion and stall back-propagation are built in. Also built in: load-use hazard detection and E-stage forwarding selects. It sits between the main decoder and the datapath, replacing hand-wired per-stage control flops.

---
 rtl/ctrl_pipe.sv | 210 +++++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - control-signal pipeline D->E->M->W with stalls, flushes, load-use and forwarding
//
// Carries a decoded control word plus destination/source registers from decode
// through the E, M and W stages. Each stage has a valid bit, an external stall
// and an external flush. Stalls propagate upstream (W stalls M, M stalls E,
// E stalls decode). A stage below a stalled stage receives a bubble.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid_d, ctrl_d          D-stage valid and decoded control word
//   rd_d, rs_d, rt_d         D-stage destination / source registers
//   use_rs_d, use_rt_d       D-stage instruction really reads rs / rt
//   stall_e/m/w, flush_e/m/w external per-stage stall / flush requests
//   stall_d                  decode must hold this cycle (combinational)
//   load_use                 load in E feeds the instruction in D (combinational)
//   valid/ctrl/rd_e/m/w      per-stage pipeline contents
//   rs_e, rt_e               E-stage source registers
//   fwd_a_e, fwd_b_e         E operand select: 00 regfile, 01 W, 10 M (combinational)
//   retired                  retire counter
//
// Optional feature: define CTRL_PIPE_PERF_EN to build the retire counter;
// otherwise retired is tied to 0.

module ctrl_pipe #(
    parameter int CTRL_W       = 16,
    parameter int REG_W        = 5,
    parameter int MEMTOREG_BIT = 0,
    parameter int REGWRITE_BIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [REG_W-1:0]  rd_d,
    input  logic [REG_W-1:0]  rs_d,
    input  logic [REG_W-1:0]  rt_d,
    input  logic              use_rs_d,
    input  logic              use_rt_d,
    input  logic              stall_e,
    input  logic              stall_m,
    input  logic              stall_w,
    input  logic              flush_e,
    input  logic              flush_m,
    input  logic              flush_w,
    output logic              stall_d,
    output logic              load_use,
    output logic              valid_e,
    output logic              valid_m,
    output logic              valid_w,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic [CTRL_W-1:0] ctrl_m,
    output logic [CTRL_W-1:0] ctrl_w,
    output logic [REG_W-1:0]  rd_e,
    output logic [REG_W-1:0]  rd_m,
    output logic [REG_W-1:0]  rd_w,
    output logic [REG_W-1:0]  rs_e,
    output logic [REG_W-1:0]  rt_e,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic [31:0]       retired
);

    // Stage registers and their next-state values
    logic              e_valid_q, e_valid_d;
    logic [CTRL_W-1:0] e_ctrl_q,  e_ctrl_d;
    logic [REG_W-1:0]  e_rd_q,    e_rd_d;
    logic [REG_W-1:0]  e_rs_q,    e_rs_d;
    logic [REG_W-1:0]  e_rt_q,    e_rt_d;
    logic              m_valid_q, m_valid_d;
    logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
    logic [REG_W-1:0]  m_rd_q,    m_rd_d;
    logic              w_valid_q, w_valid_d;
    logic [CTRL_W-1:0] w_ctrl_q,  w_ctrl_d;
    logic [REG_W-1:0]  w_rd_q,    w_rd_d;

    // Effective stalls: a stalled stage also freezes everything upstream of it
    logic st_w, st_m, st_e;
    assign st_w = stall_w;
    assign st_m = stall_m | st_w;
    assign st_e = stall_e | st_m;

    logic e_load, m_writes, w_writes;
    assign e_load   = e_valid_q & e_ctrl_q[REGWRITE_BIT] & e_ctrl_q[MEMTOREG_BIT];
    assign m_writes = m_valid_q & m_ctrl_q[REGWRITE_BIT];
    assign w_writes = w_valid_q & w_ctrl_q[REGWRITE_BIT];

    assign load_use = valid_d & e_load & (e_rd_q != '0) &
                      ((use_rs_d & (e_rd_q == rs_d)) | (use_rt_d & (e_rd_q == rt_d)));
    assign stall_d  = st_e | load_use;

    // Forwarding: M is younger than W, so it wins when both match
    always_comb begin
        fwd_a_e = 2'b00;
        fwd_b_e = 2'b00;
        if (m_writes && m_rd_q != '0 && m_rd_q == e_rs_q)      fwd_a_e = 2'b10;
        else if (w_writes && w_rd_q != '0 && w_rd_q == e_rs_q) fwd_a_e = 2'b01;
        if (m_writes && m_rd_q != '0 && m_rd_q == e_rt_q)      fwd_b_e = 2'b10;
        else if (w_writes && w_rd_q != '0 && w_rd_q == e_rt_q) fwd_b_e = 2'b01;
    end

    // E stage: a load-use hazard inserts a bubble while decode holds
    always_comb begin
        e_valid_d = e_valid_q;
        e_ctrl_d  = e_ctrl_q;
        e_rd_d    = e_rd_q;
        e_rs_d    = e_rs_q;
        e_rt_d    = e_rt_q;
        if (flush_e || (!st_e && load_use)) begin
            e_valid_d = 1'b0;
            e_ctrl_d  = '0;
            e_rd_d    = '0;
            e_rs_d    = '0;
            e_rt_d    = '0;
        end else if (!st_e) begin
            e_valid_d = valid_d;
            e_ctrl_d  = ctrl_d;
            e_rd_d    = rd_d;
            e_rs_d    = rs_d;
            e_rt_d    = rt_d;
        end
    end

    // M stage: bubble when E is frozen but M is free to move on
    always_comb begin
        m_valid_d = m_valid_q;
        m_ctrl_d  = m_ctrl_q;
        m_rd_d    = m_rd_q;
        if (flush_m || (!st_m && st_e)) begin
            m_valid_d = 1'b0;
            m_ctrl_d  = '0;
            m_rd_d    = '0;
        end else if (!st_m) begin
            m_valid_d = e_valid_q;
            m_ctrl_d  = e_ctrl_q;
            m_rd_d    = e_rd_q;
        end
    end

    // W stage: bubble when M is frozen but W is free to move on
    always_comb begin
        w_valid_d = w_valid_q;
        w_ctrl_d  = w_ctrl_q;
        w_rd_d    = w_rd_q;
        if (flush_w || (!st_w && st_m)) begin
            w_valid_d = 1'b0;
            w_ctrl_d  = '0;
            w_rd_d    = '0;
        end else if (!st_w) begin
            w_valid_d = m_valid_q;
            w_ctrl_d  = m_ctrl_q;
            w_rd_d    = m_rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid_q <= 1'b0;
            e_ctrl_q  <= '0;
            e_rd_q    <= '0;
            e_rs_q    <= '0;
            e_rt_q    <= '0;
            m_valid_q <= 1'b0;
            m_ctrl_q  <= '0;
            m_rd_q    <= '0;
            w_valid_q <= 1'b0;
            w_ctrl_q  <= '0;
            w_rd_q    <= '0;
        end else begin
            e_valid_q <= e_valid_d;
            e_ctrl_q  <= e_ctrl_d;
            e_rd_q    <= e_rd_d;
            e_rs_q    <= e_rs_d;
            e_rt_q    <= e_rt_d;
            m_valid_q <= m_valid_d;
            m_ctrl_q  <= m_ctrl_d;
            m_rd_q    <= m_rd_d;
            w_valid_q <= w_valid_d;
            w_ctrl_q  <= w_ctrl_d;
            w_rd_q    <= w_rd_d;
        end
    end

    assign valid_e = e_valid_q;
    assign ctrl_e  = e_ctrl_q;
    assign rd_e    = e_rd_q;
    assign rs_e    = e_rs_q;
    assign rt_e    = e_rt_q;
    assign valid_m = m_valid_q;
    assign ctrl_m  = m_ctrl_q;
    assign rd_m    = m_rd_q;
    assign valid_w = w_valid_q;
    assign ctrl_w  = w_ctrl_q;
    assign rd_w    = w_rd_q;

`ifdef CTRL_PIPE_PERF_EN
    // An instruction retires when it leaves W, i.e. W is valid and not held
    logic [31:0] retired_q, retired_d;
    assign retired_d = (w_valid_q && !st_w) ? retired_q + 32'd1 : retired_q;

    always_ff @(posedge clk) begin
        if (rst) retired_q <= '0;
        else     retired_q <= retired_d;
    end

    assign retired = retired_q;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - randomized self-checking bench for ctrl_pipe against a behavioural stage model

module tb_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_d;
    logic [15:0] ctrl_d;
    logic [4:0]  rd_d, rs_d, rt_d;
    logic        use_rs_d, use_rt_d;
    logic        stall_e, stall_m, stall_w;
    logic        flush_e, flush_m, flush_w;
    logic        stall_d, load_use;
    logic        valid_e, valid_m, valid_w;
    logic [15:0] ctrl_e, ctrl_m, ctrl_w;
    logic [4:0]  rd_e, rd_m, rd_w, rs_e, rt_e;
    logic [1:0]  fwd_a_e, fwd_b_e;
    logic [31:0] retired;

    always #5 clk = ~clk;

    ctrl_pipe dut (
        .clk(clk), .rst(rst), .valid_d(valid_d), .ctrl_d(ctrl_d),
        .rd_d(rd_d), .rs_d(rs_d), .rt_d(rt_d),
        .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
        .stall_e(stall_e), .stall_m(stall_m), .stall_w(stall_w),
        .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
        .stall_d(stall_d), .load_use(load_use),
        .valid_e(valid_e), .valid_m(valid_m), .valid_w(valid_w),
        .ctrl_e(ctrl_e), .ctrl_m(ctrl_m), .ctrl_w(ctrl_w),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .rs_e(rs_e), .rt_e(rt_e),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .retired(retired)
    );

    // Model: one record per stage, an instruction queue feeding decode
    typedef struct packed {
        logic        v;
        logic [15:0] c;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
    } stg_t;

    typedef struct packed {
        logic [15:0] c;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        urs;
        logic        urt;
    } ins_t;

    stg_t        me, mm, mw;
    int unsigned m_ret;
    ins_t        feedq[$];
    logic [4:0]  wq[$];
    bit          rand_bubbles;
    int          checks, failures, cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    function automatic bit writes(input stg_t s);
        return s.v && s.c[1];
    endfunction

    function automatic bit exp_lu();
        return valid_d && writes(me) && me.c[0] && me.rd != 0 &&
               ((use_rs_d && me.rd == rs_d) || (use_rt_d && me.rd == rt_d));
    endfunction

    function automatic bit exp_stall_d();
        return stall_e || stall_m || stall_w || exp_lu();
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        if (src != 0 && writes(mm) && mm.rd == src) return 2'b10;
        if (src != 0 && writes(mw) && mw.rd == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic compare();
        chk("valid_e", {31'b0, valid_e}, {31'b0, me.v});
        chk("ctrl_e", {16'b0, ctrl_e}, {16'b0, me.c});
        chk("rd_e", {27'b0, rd_e}, {27'b0, me.rd});
        chk("rs_e", {27'b0, rs_e}, {27'b0, me.rs});
        chk("rt_e", {27'b0, rt_e}, {27'b0, me.rt});
        chk("valid_m", {31'b0, valid_m}, {31'b0, mm.v});
        chk("ctrl_m", {16'b0, ctrl_m}, {16'b0, mm.c});
        chk("rd_m", {27'b0, rd_m}, {27'b0, mm.rd});
        chk("valid_w", {31'b0, valid_w}, {31'b0, mw.v});
        chk("ctrl_w", {16'b0, ctrl_w}, {16'b0, mw.c});
        chk("rd_w", {27'b0, rd_w}, {27'b0, mw.rd});
        chk("load_use", {31'b0, load_use}, {31'b0, exp_lu()});
        chk("stall_d", {31'b0, stall_d}, {31'b0, exp_stall_d()});
        chk("fwd_a_e", {30'b0, fwd_a_e}, {30'b0, exp_fwd(me.rs)});
        chk("fwd_b_e", {30'b0, fwd_b_e}, {30'b0, exp_fwd(me.rt)});
`ifdef CTRL_PIPE_PERF_EN
        chk("retired", retired, m_ret);
`else
        chk("retired", retired, 32'd0);
`endif
    endtask

    task automatic present_head();
        if (feedq.size() > 0 && !(rand_bubbles && $urandom_range(0, 3) == 0)) begin
            valid_d  = 1'b1;
            ctrl_d   = feedq[0].c;
            rd_d     = feedq[0].rd;
            rs_d     = feedq[0].rs;
            rt_d     = feedq[0].rt;
            use_rs_d = feedq[0].urs;
            use_rt_d = feedq[0].urt;
        end else begin
            valid_d  = 1'b0;
            ctrl_d   = '0;
            rd_d     = '0;
            rs_d     = '0;
            rt_d     = '0;
            use_rs_d = 1'b0;
            use_rt_d = 1'b0;
        end
    endtask

    // Called at a negedge with inputs settled; returns at the next negedge
    task automatic step();
        stg_t        ne, nm, nw;
        int unsigned nret;
        bit          sw, sm, se, lu, take;
        #1;
        compare();
        sw = stall_w;
        sm = stall_m || sw;
        se = stall_e || sm;
        lu = exp_lu();
        take = valid_d && !exp_stall_d() && !rst;
        if (rst) begin
            ne = '0; nm = '0; nw = '0; nret = 0;
        end else begin
            nret = (mw.v && !sw) ? m_ret + 1 : m_ret;
            if (flush_w)    nw = '0;
            else if (sw)    nw = mw;
            else if (sm)    nw = '0;
            else            nw = mm;
            if (flush_m)    nm = '0;
            else if (sm)    nm = mm;
            else if (se)    nm = '0;
            else            nm = me;
            if (flush_e)    ne = '0;
            else if (se)    ne = me;
            else if (lu)    ne = '0;
            else            ne = {valid_d, ctrl_d, rd_d, rs_d, rt_d};
            if (valid_w && !stall_w) wq.push_back(rd_w);
        end
        @(posedge clk);
        me = ne; mm = nm; mw = nw; m_ret = nret;
        if (take) void'(feedq.pop_front());
        cyc++;
        @(negedge clk);
        present_head();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic ins_t mk(input logic [15:0] c, input logic [4:0] rd,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt);
        ins_t x;
        x.c = c; x.rd = rd; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt;
        return x;
    endfunction

    initial begin
        checks = 0; failures = 0; cyc = 0; m_ret = 0;
        me = '0; mm = '0; mw = '0;
        rand_bubbles = 1'b0;
        rst = 1'b1;
        stall_e = 0; stall_m = 0; stall_w = 0;
        flush_e = 0; flush_m = 0; flush_w = 0;
        present_head();
        @(negedge clk);
        steps(2);
        rst = 1'b0;
        #1;
        chk("reset_valid_e", {31'b0, valid_e}, 32'd0);
        chk("reset_valid_w", {31'b0, valid_w}, 32'd0);
        chk("reset_stall_d", {31'b0, stall_d}, 32'd0);
        chk("reset_fwd_a", {30'b0, fwd_a_e}, 32'd0);
        chk("reset_retired", retired, 32'd0);

        // lw r3 ; add r4,r3,r5
        feedq.push_back(mk(16'h0003, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0));
        feedq.push_back(mk(16'h0002, 5'd4, 5'd3, 5'd5, 1'b1, 1'b1));
        present_head();
        step();
        #1;
        chk("lu_load_use", {31'b0, load_use}, 32'd1);
        chk("lu_stall_d", {31'b0, stall_d}, 32'd1);
        step();
        #1;
        chk("lu_bubble_e", {31'b0, valid_e}, 32'd0);
        chk("lu_released", {31'b0, load_use}, 32'd0);
        step();
        #1;
        chk("lu_fwd_a_w", {30'b0, fwd_a_e}, 32'd1);
        chk("lu_fwd_b_none", {30'b0, fwd_b_e}, 32'd0);
        steps(4);

        // add r2 ; add r2 ; sub using r2 -> M wins
        feedq.push_back(mk(16'h0002, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0));
        feedq.push_back(mk(16'h0002, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0));
        feedq.push_back(mk(16'h0002, 5'd6, 5'd2, 5'd7, 1'b1, 1'b1));
        present_head();
        steps(3);
        #1;
        chk("fwd_m_wins", {30'b0, fwd_a_e}, 32'd2);
        steps(4);
        feedq.push_back(mk(16'h0002, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0));
        feedq.push_back(mk(16'h0002, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0));
        feedq.push_back(mk(16'h0002, 5'd6, 5'd0, 5'd7, 1'b1, 1'b1));
        present_head();
        steps(3);
        #1;
        chk("fwd_r0_none", {30'b0, fwd_a_e}, 32'd0);
        steps(4);

        // stall_m for 3 cycles with 4 back-to-back instructions
        wq.delete();
        for (int i = 1; i <= 4; i++) feedq.push_back(mk(16'h0002, 5'(i), 5'd0, 5'd0, 1'b0, 1'b0));
        present_head();
        steps(2);
        stall_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stallm_stall_d", {31'b0, stall_d}, 32'd1);
            step();
        end
        stall_m = 1'b0;
        steps(6);
        chk("stallm_retire_count", wq.size(), 32'd4);
        for (int i = 0; i < 4 && i < wq.size(); i++)
            chk("stallm_retire_order", {27'b0, wq[i]}, i + 1);

        // flush_e together with stall_e
        feedq.push_back(mk(16'h0002, 5'd7, 5'd1, 5'd1, 1'b0, 1'b0));
        present_head();
        step();
        stall_e = 1'b1;
        flush_e = 1'b1;
        #1;
        chk("flushe_stall_d", {31'b0, stall_d}, 32'd1);
        step();
        flush_e = 1'b0;
        #1;
        chk("flushe_bubble", {31'b0, valid_e}, 32'd0);
        chk("flushe_stall_held", {31'b0, stall_d}, 32'd1);
        step();
        stall_e = 1'b0;
        steps(4);

        // 10 instructions with 2 cycles of stall_w, counted from reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) feedq.push_back(mk(16'h0002, 5'(i), 5'd0, 5'd0, 1'b0, 1'b0));
        present_head();
        steps(4);
        stall_w = 1'b1;
        steps(2);
        stall_w = 1'b0;
        steps(14);
`ifdef CTRL_PIPE_PERF_EN
        chk("perf_retired_10", retired, 32'd10);
`else
        chk("perf_absent", retired, 32'd0);
`endif

        // reset mid-stream with stall_m and all stages valid
        for (int i = 1; i <= 5; i++) feedq.push_back(mk(16'h0006, 5'(i), 5'd0, 5'd0, 1'b0, 1'b0));
        present_head();
        steps(3);
        stall_m = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        stall_m = 1'b0;
        #1;
        chk("rst_valid_e", {31'b0, valid_e}, 32'd0);
        chk("rst_valid_m", {31'b0, valid_m}, 32'd0);
        chk("rst_valid_w", {31'b0, valid_w}, 32'd0);
        chk("rst_ctrl_m", {16'b0, ctrl_m}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        feedq.delete();
        present_head();

        // randomized traffic with small register numbers to provoke hazards
        rand_bubbles = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            while (feedq.size() < 4)
                feedq.push_back(mk(16'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                                   5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom)));
            stall_e = ($urandom_range(0, 9) == 0);
            stall_m = ($urandom_range(0, 11) == 0);
            stall_w = ($urandom_range(0, 13) == 0);
            flush_e = ($urandom_range(0, 19) == 0);
            flush_m = ($urandom_range(0, 19) == 0);
            flush_w = ($urandom_range(0, 19) == 0);
            rst     = ($urandom_range(0, 199) == 0);
            present_head();
            step();
        end
        rst = 0; stall_e = 0; stall_m = 0; stall_w = 0;
        flush_e = 0; flush_m = 0; flush_w = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
